priority_mux: RTL and testbench

PRIORITY_MUX -- requirements
Module: priority_mux

---
 rtl/priority_mux.sv | 86 ++++++++
 tb/tb_priority_mux.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_mux.sv
// priority_mux
//   Selects one of CNT packed data lanes. The lowest-index set bit of sel
//   wins, so sel[0] has the highest priority. Only the winning lane ever
//   reaches dout; lanes are never ORed together.
//
// Parameters
//   WIDTH   : bits per lane and width of dout
//   CNT     : number of lanes (1..64)
//   REG_OUT : 0 = combinational outputs, 1 = outputs registered (1 cycle)
//
// Ports
//   clk   : clock, rising edge (used only when REG_OUT = 1)
//   rst_n : asynchronous active-low reset (used only when REG_OUT = 1)
//   din   : packed lanes, lane i = din[i*WIDTH +: WIDTH]
//   sel   : per-lane select request
//   dout  : data of the winning lane, 0 when nothing is selected
//   hit   : any sel bit set
//   grant : one-hot copy of the winning sel bit
//   idx   : binary index of the winning lane, 0 when nothing is selected
module priority_mux #(
  parameter int WIDTH   = 4,
  parameter int CNT     = 1,
  parameter bit REG_OUT = 1'b0,
  localparam int IW     = (CNT > 1) ? $clog2(CNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH*CNT-1:0] din,
  input  logic [CNT-1:0]       sel,
  output logic [WIDTH-1:0]     dout,
  output logic                 hit,
  output logic [CNT-1:0]       grant,
  output logic [IW-1:0]        idx
);

  logic [WIDTH-1:0] comb_dout;
  logic             comb_hit;
  logic [CNT-1:0]   comb_grant;
  logic [IW-1:0]    comb_idx;

  // Scan upward; the first set bit claims the result and later bits are
  // ignored because comb_hit is already set.
  always_comb begin
    comb_dout  = '0;
    comb_hit   = 1'b0;
    comb_grant = '0;
    comb_idx   = '0;
    for (int i = 0; i < CNT; i++) begin
      if (sel[i] && !comb_hit) begin
        comb_hit      = 1'b1;
        comb_grant[i] = 1'b1;
        comb_idx      = IW'(i);
        comb_dout     = din[i*WIDTH +: WIDTH];
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      // Captured on every edge with no enable, so glitches on din/sel
      // between edges never reach the outputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout  <= '0;
          hit   <= 1'b0;
          grant <= '0;
          idx   <= '0;
        end else begin
          dout  <= comb_dout;
          hit   <= comb_hit;
          grant <= comb_grant;
          idx   <= comb_idx;
        end
      end
    end else begin : g_comb
      // Pure combinational path; clock and reset are intentionally ignored.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout  = comb_dout;
      assign hit   = comb_hit;
      assign grant = comb_grant;
      assign idx   = comb_idx;
    end
  endgenerate

endmodule

// File: tb/tb_priority_mux.sv
module tb_priority_mux;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4, CNT=2, combinational
  logic [7:0] din2;
  logic [1:0] sel2;
  logic [3:0] dout2;
  logic       hit2;
  logic [1:0] grant2;
  logic [0:0] idx2;

  // WIDTH=8, CNT=4, combinational
  logic [31:0] din4;
  logic [3:0]  sel4;
  logic [7:0]  dout4;
  logic        hit4;
  logic [3:0]  grant4;
  logic [1:0]  idx4;

  // WIDTH=8, CNT=4, registered
  logic [31:0] dinr;
  logic [3:0]  selr;
  logic [7:0]  doutr;
  logic        hitr;
  logic [3:0]  grantr;
  logic [1:0]  idxr;

  // WIDTH=4, CNT=1, combinational
  logic [3:0] din1;
  logic [0:0] sel1;
  logic [3:0] dout1;
  logic       hit1;
  logic [0:0] grant1;
  logic [0:0] idx1;

  // WIDTH=4, CNT=7, combinational
  logic [27:0] din7;
  logic [6:0]  sel7;
  logic [3:0]  dout7;
  logic        hit7;
  logic [6:0]  grant7;
  logic [2:0]  idx7;

  priority_mux #(.WIDTH(4), .CNT(2), .REG_OUT(1'b0)) u_c2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .sel(sel2),
    .dout(dout2), .hit(hit2), .grant(grant2), .idx(idx2));

  priority_mux #(.WIDTH(8), .CNT(4), .REG_OUT(1'b0)) u_c4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4),
    .dout(dout4), .hit(hit4), .grant(grant4), .idx(idx4));

  priority_mux #(.WIDTH(8), .CNT(4), .REG_OUT(1'b1)) u_r4 (
    .clk(clk), .rst_n(rst_n), .din(dinr), .sel(selr),
    .dout(doutr), .hit(hitr), .grant(grantr), .idx(idxr));

  priority_mux #(.WIDTH(4), .CNT(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .sel(sel1),
    .dout(dout1), .hit(hit1), .grant(grant1), .idx(idx1));

  priority_mux #(.WIDTH(4), .CNT(7), .REG_OUT(1'b0)) u_c7 (
    .clk(clk), .rst_n(rst_n), .din(din7), .sel(sel7),
    .dout(dout7), .hit(hit7), .grant(grant7), .idx(idx7));

  // Reference for CNT=7: isolate lowest set bit with s & -s, then decode.
  // Result packed as {hit, idx[2:0], grant[6:0], dout[3:0]}.
  function automatic logic [14:0] model7(input logic [27:0] d, input logic [6:0] s);
    logic [6:0] g;
    logic [2:0] x;
    logic [3:0] o;
    g = s & (~s + 7'd1);
    x = '0;
    o = '0;
    for (int k = 0; k < 7; k++) begin
      if (g[k]) begin
        x = 3'(k);
        o = d[k*4 +: 4];
      end
    end
    return {(s != 7'd0), x, g, o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    dinr  = 32'h44332211;
    selr  = 4'b0001;
    din4  = 32'h44332211;
    sel4  = 4'b0100;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_regout: got %h want %h", {hitr, idxr, grantr, doutr}, 15'd0);
    end
    // Combinational instance ignores reset.
    n_cmp++;
    if ({hit4, idx4, grant4, dout4} !== {1'b1, 2'd2, 4'b0100, 8'h33}) begin
      n_bad++;
      $display("FAIL reset_comb_ignored: got %h want %h",
               {hit4, idx4, grant4, dout4}, {1'b1, 2'd2, 4'b0100, 8'h33});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_lane();
    din2 = 8'hA5;
    sel2 = 2'b01;
    #1;
    n_cmp++;
    if ({hit2, idx2, grant2, dout2} !== {1'b1, 1'b0, 2'b01, 4'h5}) begin
      n_bad++;
      $display("FAIL two_lane_sel01: got %h want %h", {hit2, idx2, grant2, dout2}, {1'b1, 1'b0, 2'b01, 4'h5});
    end
    sel2 = 2'b10;
    #1;
    n_cmp++;
    if ({hit2, idx2, grant2, dout2} !== {1'b1, 1'b1, 2'b10, 4'hA}) begin
      n_bad++;
      $display("FAIL two_lane_sel10: got %h want %h", {hit2, idx2, grant2, dout2}, {1'b1, 1'b1, 2'b10, 4'hA});
    end
    sel2 = 2'b11;
    #1;
    n_cmp++;
    if ({hit2, idx2, grant2, dout2} !== {1'b1, 1'b0, 2'b01, 4'h5}) begin
      n_bad++;
      $display("FAIL two_lane_sel11: got %h want %h", {hit2, idx2, grant2, dout2}, {1'b1, 1'b0, 2'b01, 4'h5});
    end
  endtask

  task automatic test_priority();
    din4 = {8'h44, 8'h33, 8'h22, 8'h11};
    sel4 = 4'b1110;
    #1;
    n_cmp++;
    if ({hit4, idx4, grant4, dout4} !== {1'b1, 2'd1, 4'b0010, 8'h22}) begin
      n_bad++;
      $display("FAIL prio_1110: got %h want %h", {hit4, idx4, grant4, dout4}, {1'b1, 2'd1, 4'b0010, 8'h22});
    end
    sel4 = 4'b1111;
    #1;
    n_cmp++;
    if ({hit4, idx4, grant4, dout4} !== {1'b1, 2'd0, 4'b0001, 8'h11}) begin
      n_bad++;
      $display("FAIL prio_1111: got %h want %h", {hit4, idx4, grant4, dout4}, {1'b1, 2'd0, 4'b0001, 8'h11});
    end
    sel4 = 4'b1000;
    #1;
    n_cmp++;
    if ({hit4, idx4, grant4, dout4} !== {1'b1, 2'd3, 4'b1000, 8'h44}) begin
      n_bad++;
      $display("FAIL prio_1000: got %h want %h", {hit4, idx4, grant4, dout4}, {1'b1, 2'd3, 4'b1000, 8'h44});
    end
    // Unselected lanes must not leak in.
    sel4 = 4'b0100;
    din4 = {8'hFF, 8'h3C, 8'hFF, 8'hFF};
    #1;
    n_cmp++;
    if ({hit4, idx4, grant4, dout4} !== {1'b1, 2'd2, 4'b0100, 8'h3C}) begin
      n_bad++;
      $display("FAIL prio_isolation: got %h want %h", {hit4, idx4, grant4, dout4}, {1'b1, 2'd2, 4'b0100, 8'h3C});
    end
  endtask

  task automatic test_no_select();
    din4 = 32'hDEADBEEF;
    sel4 = 4'b0000;
    din2 = 8'hFF;
    sel2 = 2'b00;
    #1;
    n_cmp++;
    if ({hit4, idx4, grant4, dout4} !== 15'd0) begin
      n_bad++;
      $display("FAIL no_sel_cnt4: got %h want %h", {hit4, idx4, grant4, dout4}, 15'd0);
    end
    n_cmp++;
    if ({hit2, idx2, grant2, dout2} !== 8'd0) begin
      n_bad++;
      $display("FAIL no_sel_cnt2: got %h want %h", {hit2, idx2, grant2, dout2}, 8'd0);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    dinr = {8'h44, 8'h33, 8'h22, 8'h11};
    selr = 4'b0001;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== {1'b1, 2'd0, 4'b0001, 8'h11}) begin
      n_bad++;
      $display("FAIL reg_lane0: got %h want %h", {hitr, idxr, grantr, doutr}, {1'b1, 2'd0, 4'b0001, 8'h11});
    end
    // Change inputs between edges: outputs must hold.
    @(negedge clk);
    selr = 4'b1000;
    dinr[7:0] = 8'h99;
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== {1'b1, 2'd0, 4'b0001, 8'h11}) begin
      n_bad++;
      $display("FAIL reg_hold: got %h want %h", {hitr, idxr, grantr, doutr}, {1'b1, 2'd0, 4'b0001, 8'h11});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== {1'b1, 2'd3, 4'b1000, 8'h44}) begin
      n_bad++;
      $display("FAIL reg_lane3: got %h want %h", {hitr, idxr, grantr, doutr}, {1'b1, 2'd3, 4'b1000, 8'h44});
    end
    @(negedge clk);
    selr = 4'b0000;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== 15'd0) begin
      n_bad++;
      $display("FAIL reg_nosel: got %h want %h", {hitr, idxr, grantr, doutr}, 15'd0);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    dinr = {8'h44, 8'h33, 8'h22, 8'h11};
    selr = 4'b1000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (doutr !== 8'h44) begin
      n_bad++;
      $display("FAIL arst_preload: got %h want %h", doutr, 8'h44);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== 15'd0) begin
      n_bad++;
      $display("FAIL arst_immediate: got %h want %h", {hitr, idxr, grantr, doutr}, 15'd0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== 15'd0) begin
      n_bad++;
      $display("FAIL arst_held: got %h want %h", {hitr, idxr, grantr, doutr}, 15'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    selr  = 4'b0110;
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== 15'd0) begin
      n_bad++;
      $display("FAIL arst_release_hold: got %h want %h", {hitr, idxr, grantr, doutr}, 15'd0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({hitr, idxr, grantr, doutr} !== {1'b1, 2'd1, 4'b0010, 8'h22}) begin
      n_bad++;
      $display("FAIL arst_reload: got %h want %h", {hitr, idxr, grantr, doutr}, {1'b1, 2'd1, 4'b0010, 8'h22});
    end
  endtask

  task automatic test_random();
    logic [14:0] exp7;
    logic [6:0]  exp1;
    for (int n = 0; n < 1000; n++) begin
      din1 = 4'($urandom);
      sel1 = 1'($urandom);
      din7 = 28'($urandom);
      sel7 = 7'($urandom_range(0, 127));
      #1;
      exp1 = sel1[0] ? {1'b1, 1'b0, 1'b1, din1} : 7'd0;
      exp7 = model7(din7, sel7);
      n_cmp++;
      if ({hit1, idx1, grant1, dout1} !== exp1) begin
        n_bad++;
        $display("FAIL rand_cnt1 #%0d: got %h want %h", n, {hit1, idx1, grant1, dout1}, exp1);
      end
      n_cmp++;
      if ({hit7, idx7, grant7, dout7} !== exp7) begin
        n_bad++;
        $display("FAIL rand_cnt7 #%0d sel=%b: got %h want %h", n, sel7, {hit7, idx7, grant7, dout7}, exp7);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    din2 = '0; sel2 = '0;
    din4 = '0; sel4 = '0;
    dinr = '0; selr = '0;
    din1 = '0; sel1 = '0;
    din7 = '0; sel7 = '0;
    test_reset();
    test_two_lane();
    test_priority();
    test_no_select();
    test_registered();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
